// File: rtl/dmem_lane_ctrl_if.sv
// Bundle, RAM-port and result signals of the dual-lane data-memory controller.
// slave = controller side, master = pipeline/RAM environment side.
interface dmem_lane_ctrl_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic              l1_en;
  logic              l1_we;
  logic [31:0]       l1_addr;
  logic [DATA_W-1:0] l1_wdata;
  logic              l2_en;
  logic              l2_we;
  logic [31:0]       l2_addr;
  logic [DATA_W-1:0] l2_wdata;

  logic              memtoregm;
  logic              memtoregm2;
  logic              memwritem;
  logic              memwritem2;
  logic [ADDR_W-1:0] aluoutm;
  logic [ADDR_W-1:0] aluoutm2;
  logic [DATA_W-1:0] writedatam;
  logic [DATA_W-1:0] writedatam2;
  logic [DATA_W-1:0] readdatam;
  logic [DATA_W-1:0] readdatam2;

  logic              out_valid;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic              err1;
  logic              err2;

  modport slave (
    input  in_valid, l1_en, l1_we, l1_addr, l1_wdata,
           l2_en, l2_we, l2_addr, l2_wdata, readdatam, readdatam2,
    output in_ready, memtoregm, memtoregm2, memwritem, memwritem2,
           aluoutm, aluoutm2, writedatam, writedatam2,
           out_valid, rdata1, rdata2, err1, err2
  );

  modport master (
    output in_valid, l1_en, l1_we, l1_addr, l1_wdata,
           l2_en, l2_we, l2_addr, l2_wdata, readdatam, readdatam2,
    input  in_ready, memtoregm, memtoregm2, memwritem, memwritem2,
           aluoutm, aluoutm2, writedatam, writedatam2,
           out_valid, rdata1, rdata2, err1, err2
  );
endinterface

// File: rtl/dmem_lane_ctrl.sv
// Dual-lane data-RAM initiator: issues lane accesses on two RAM ports in program
// order, splitting a same-word load/store mix over two cycles, and registers results.
module dmem_lane_ctrl #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  dmem_lane_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    ISSUE2 = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic              r1_en_q, r1_we_q, r1_err_q;
  logic              r2_en_q, r2_we_q, r2_err_q;
  logic [ADDR_W-1:0] r1_idx_q, r2_idx_q;
  logic [DATA_W-1:0] r1_wdata_q, r2_wdata_q;

  logic [DATA_W-1:0] hold1_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] rdata1_q, rdata2_q;
  logic              err1_q, err2_q;

  logic l1_go, l2_go, same_word, conflict, l1_shadowed, accept;
  logic p1_act, p2_act;

  function automatic logic addr_fault(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> (ADDR_W + 2)) != 32'd0);
  endfunction

  assign l1_go       = r1_en_q && !r1_err_q;
  assign l2_go       = r2_en_q && !r2_err_q;
  assign same_word   = (r1_idx_q == r2_idx_q);
  assign conflict    = l1_go && l2_go && same_word && (r1_we_q != r2_we_q);
  // Two stores to one word: the younger lane's value is the architectural result.
  assign l1_shadowed = l1_go && l2_go && same_word && r1_we_q && r2_we_q;

  assign bus.in_ready = !((state_q == ISSUE) && conflict);
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    p1_act = 1'b0;
    p2_act = 1'b0;
    unique case (state_q)
      ISSUE: begin
        p1_act = l1_go && !l1_shadowed;
        p2_act = l2_go && !conflict;
      end
      ISSUE2:  p2_act = l2_go;
      default: ;
    endcase
  end

  always_comb begin
    bus.memtoregm   = p1_act && !r1_we_q;
    bus.memwritem   = p1_act &&  r1_we_q;
    bus.aluoutm     = p1_act ? r1_idx_q : '0;
    bus.writedatam  = (p1_act && r1_we_q) ? r1_wdata_q : '0;
    bus.memtoregm2  = p2_act && !r2_we_q;
    bus.memwritem2  = p2_act &&  r2_we_q;
    bus.aluoutm2    = p2_act ? r2_idx_q : '0;
    bus.writedatam2 = (p2_act && r2_we_q) ? r2_wdata_q : '0;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE: begin
        if (conflict)    state_d = ISSUE2;
        else if (accept) state_d = ISSUE;
        else             state_d = IDLE;
      end
      ISSUE2:  state_d = accept ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_en_q    <= 1'b0;
      r1_we_q    <= 1'b0;
      r1_err_q   <= 1'b0;
      r1_idx_q   <= '0;
      r1_wdata_q <= '0;
      r2_en_q    <= 1'b0;
      r2_we_q    <= 1'b0;
      r2_err_q   <= 1'b0;
      r2_idx_q   <= '0;
      r2_wdata_q <= '0;
    end else if (accept) begin
      r1_en_q    <= bus.l1_en;
      r1_we_q    <= bus.l1_we;
      r1_err_q   <= bus.l1_en && addr_fault(bus.l1_addr);
      r1_idx_q   <= bus.l1_addr[ADDR_W+1:2];
      r1_wdata_q <= bus.l1_wdata;
      r2_en_q    <= bus.l2_en;
      r2_we_q    <= bus.l2_we;
      r2_err_q   <= bus.l2_en && addr_fault(bus.l2_addr);
      r2_idx_q   <= bus.l2_addr[ADDR_W+1:2];
      r2_wdata_q <= bus.l2_wdata;
    end
  end

  // A split bundle parks lane 1's load data until lane 2 completes in ISSUE2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold1_q     <= '0;
      out_valid_q <= 1'b0;
      rdata1_q    <= '0;
      rdata2_q    <= '0;
      err1_q      <= 1'b0;
      err2_q      <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (state_q == ISSUE && conflict) begin
        hold1_q <= bus.memtoregm ? bus.readdatam : '0;
      end else if (state_q == ISSUE) begin
        out_valid_q <= 1'b1;
        rdata1_q    <= bus.memtoregm  ? bus.readdatam  : '0;
        rdata2_q    <= bus.memtoregm2 ? bus.readdatam2 : '0;
        err1_q      <= r1_err_q;
        err2_q      <= r2_err_q;
      end else if (state_q == ISSUE2) begin
        out_valid_q <= 1'b1;
        rdata1_q    <= hold1_q;
        rdata2_q    <= bus.memtoregm2 ? bus.readdatam2 : '0;
        err1_q      <= r1_err_q;
        err2_q      <= r2_err_q;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.rdata2    = rdata2_q;
  assign bus.err1      = err1_q;
  assign bus.err2      = err2_q;

endmodule

// File: doc/dmem_lane_ctrl.md
# dmem_lane_ctrl

Initiator side of the dual-port data RAM in the dual-issue MIPS pipeline. The block accepts one memory-stage bundle of up to two lanes (lane 1 older, lane 2 younger) and drives the RAM's two port groups with correctly ordered, single-cycle read/write strobes. When both lanes touch the same word with a read/write mix, it serialises the two accesses over two cycles. Load data is registered and returned to writeback.

## Interface
Parameters:
- ADDR_W, 12, RAM word-address width; RAM holds 2**ADDR_W words.
- DATA_W, 32, data width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  bundle present.
- in_ready  out  1  bundle accepted at an edge where in_valid && in_ready.
- lN_en  in  1  lane N (N=1,2) carries a memory op.
- lN_we  in  1  lane N: 1 = store, 0 = load.
- lN_addr  in  32  lane N byte address.
- lN_wdata  in  DATA_W  lane N store data.
- memtoregm, memtoregm2  out  1  RAM read enables for port 1 and port 2.
- memwritem, memwritem2  out  1  RAM write enables for port 1 and port 2.
- aluoutm, aluoutm2  out  ADDR_W  RAM word addresses.
- writedatam, writedatam2  out  DATA_W  RAM write data.
- readdatam, readdatam2  in  DATA_W  RAM read data (combinational).
- out_valid  out  1  one-cycle pulse: result registers hold a completed bundle.
- rdata1, rdata2  out  DATA_W  load results; 0 for a store, a disabled lane, or an error.
- err1, err2  out  1  lane fault: misaligned or out of range.

## Operation
- Word index: lN_addr[ADDR_W+1:2].
- Fault: lN_addr[1:0] != 0, or any of lN_addr[31:ADDR_W+2] != 0. A faulting lane issues no RAM access and sets errN=1.
- On accept, the bundle is latched into a request register. RAM ports are driven only from this register, never from the inputs.
- Conflict: both lanes are enabled and non-faulting, they share a word index, and exactly one of them is a store.
- Both lanes store to the same word: lane 1's write is suppressed and only lane 2 writes. This is not a split.
- Both lanes load the same word: both ports read in the same cycle. This is not a split.
- States:
  - IDLE: all RAM strobes 0.
  - ISSUE: drive lane 1 on port 1. Drive lane 2 on port 2, unless there is a conflict, in which case port 2 is idle.
  - ISSUE2: drive lane 2 only, on port 2; port 1 is idle.
- Transitions:
  - IDLE → ISSUE on accept.
  - ISSUE → ISSUE2 on conflict.
  - ISSUE → ISSUE on accept.
  - ISSUE → IDLE otherwise.
  - ISSUE2 → ISSUE on accept, else IDLE.
- in_ready = !(state == ISSUE && conflict).
- Strobe rules:
  - Read and write strobes are never both high on one port.
  - Strobes are 0 on any port not carrying an access.
  - aluoutm* and writedatam* are 0 when their port is idle.

## Timing
- Reset (async): state=IDLE; in_ready=1; out_valid=0; rdata1=rdata2=0; err1=err2=0; all six RAM strobes 0; addresses and write data 0.
- Reset mid-bundle discards it; a pending ISSUE2 never issues.
- Normal latency:
  - Accept at edge E0.
  - RAM access during E0–E1.
  - Read data captured at E1; out_valid=1 during E1–E2.
- Split latency:
  - Lane 1 accessed E0–E1; rdata1 is held internally.
  - Lane 2 accessed E1–E2.
  - out_valid=1 during E2–E3; in_ready=0 during E0–E1.
- Back-to-back non-conflicting bundles sustain one bundle per cycle.
- out_valid pulses exactly once per accepted bundle, including all-disabled and all-fault bundles.
- There is no output backpressure.
- Result registers hold their value until the next out_valid.
- Write strobe width is exactly one cycle per store.

## Test plan
- Reset asserted mid-ISSUE2 → all strobes drop immediately; out_valid stays 0; state IDLE, in_ready=1 after release.
- Lane 1 stores 0xDEADBEEF @0x40, lane 2 loads @0x80 (previously 0x12345678) → memwritem=1 with aluoutm=0x10 and memtoregm2=1 with aluoutm2=0x20 in the same cycle; next cycle out_valid=1, rdata2=0x12345678, rdata1=0.
- Lane 1 stores 0xA5A5A5A5 @0x100, lane 2 loads @0x100 → cycle 1 memwritem only; cycle 2 memtoregm2 only; in_ready=0 in cycle 1; rdata2=0xA5A5A5A5 with out_valid one cycle later than normal.
- Lane 1 loads @0x100, lane 2 stores 0x0 @0x100 → lane 1's load precedes the store; rdata1=0xA5A5A5A5; subsequent load @0x100 returns 0.
- Both lanes store @0x8 (0x1 then 0x2) → memwritem=0, memwritem2=1; later load returns 0x2.
- Lane 1 @0x6 (misaligned), lane 2 @0x10000 (out of range) → no strobes; out_valid=1 with err1=err2=1, rdata1=rdata2=0.
